vid_stream_timing_out: RTL

- Parametrised clocked-video output stage: converts an Avalon-ST video stream (ready/valid with sop/eop) into raster video.
- Raster outputs: data, datavalid, h/v sync, h/v blanking, field, plus underflow and lock status.
- Successor to the fixed 24-bit CVO path. Adds configurable bits-per-symbol, channel count, raster geometry, sync polarity, an internal elastic FIFO and frame re-lock after underflow.
- Sits between the frame-buffer reader and the HDMI transmitter pins.

---
 rtl/vid_timing_pkg.sv | 23 ++
 rtl/vid_fifo_fwft.sv | 49 ++++
 rtl/vid_stream_timing_out.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// Shared types and raster-geometry helpers for the clocked-video output stage.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_WAIT = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Counter width wide enough to hold 0 .. total-1.
  function automatic int cnt_w(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vid_fifo_fwft.sv
// First-word-fall-through elastic FIFO; the head word is visible on o_rd_data while !o_empty.
module vid_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Extra pointer MSB distinguishes full from empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/vid_stream_timing_out.sv
// Clocked-video output: drains an Avalon-ST frame stream into a free-running raster,
// re-locking to the next sop at the frame origin after any underflow.
module vid_stream_timing_out
  import vid_timing_pkg::*;
#(
  parameter int BPS        = 8,
  parameter int CHANNELS   = 3,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int SYNC_POL   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    enable,
  input  logic [BPS*CHANNELS-1:0] din_data,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    din_sop,
  input  logic                    din_eop,
  output logic [BPS*CHANNELS-1:0] vid_data,
  output logic                    vid_datavalid,
  output logic                    vid_h_sync,
  output logic                    vid_v_sync,
  output logic                    vid_h,
  output logic                    vid_v,
  output logic                    vid_f,
  output logic                    underflow,
  output logic                    locked
);
  localparam int DW = BPS * CHANNELS;
  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(HT - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(VT - 1);
  localparam logic          SP       = (SYNC_POL != 0);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic            w_full, w_empty, w_flush, w_push, w_pop;
  logic [DW+1:0]   w_head;
  logic [DW-1:0]   w_head_data;
  logic            w_head_sop;
  logic            w_unused_eop;
  logic            w_h_act, w_v_act, w_act, w_hs, w_vs, w_origin, w_run_en;
  logic            w_uflow;
  logic [DW-1:0]   w_pix;
  logic [DW-1:0]   r_data_p1;
  logic            r_vld_p1, r_hblank_p1, r_vblank_p1, r_hsync_p1, r_vsync_p1, r_uflow_p1;

  assign w_run_en  = enable && (r_state != ST_IDLE);
  assign w_flush   = !w_run_en;
  assign din_ready = !w_full && (r_state != ST_IDLE);
  assign w_push    = din_valid && din_ready;

  vid_fifo_fwft #(.WIDTH(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (clk_clk),
    .i_rst_n   (reset_reset_n),
    .i_flush   (w_flush),
    .i_wr_en   (w_push),
    .i_wr_data ({din_eop, din_sop, din_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // eop travels with the word but lock is judged purely on sop at the origin.
  assign w_head_data  = w_head[DW-1:0];
  assign w_head_sop   = w_head[DW];
  assign w_unused_eop = w_head[DW+1];

  assign w_h_act  = (r_h_cnt < H_ACT_C);
  assign w_v_act  = (r_v_cnt < V_ACT_C);
  assign w_act    = w_h_act && w_v_act;
  assign w_hs     = (r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C);
  assign w_vs     = (r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C);
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_uflow     = 1'b0;
    w_pix       = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_SYNC_WAIT;
      end
      ST_SYNC_WAIT: begin
        if (!w_empty) begin
          if (!w_head_sop) begin
            w_pop = 1'b1;
          end else if (w_origin) begin
            w_pop       = 1'b1;
            w_pix       = w_head_data;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A sop away from the origin, or a non-sop word at the origin, means the frame is misaligned.
        if (w_act) begin
          if (w_empty || (w_head_sop != w_origin)) begin
            w_uflow     = 1'b1;
            w_state_nxt = ST_SYNC_WAIT;
          end else begin
            w_pop = 1'b1;
            w_pix = w_head_data;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_pop       = 1'b0;
      w_uflow     = 1'b0;
      w_pix       = '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run_en) begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST_C) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST_C) ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  // Stage p1: registered raster outputs, one cycle behind the counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_data_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_hblank_p1 <= 1'b0;
      r_vblank_p1 <= 1'b0;
      r_hsync_p1  <= !SP;
      r_vsync_p1  <= !SP;
      r_uflow_p1  <= 1'b0;
    end else if (!w_run_en) begin
      r_data_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_hblank_p1 <= 1'b0;
      r_vblank_p1 <= 1'b0;
      r_hsync_p1  <= !SP;
      r_vsync_p1  <= !SP;
      r_uflow_p1  <= 1'b0;
    end else begin
      r_data_p1   <= w_pix;
      r_vld_p1    <= w_act;
      r_hblank_p1 <= !w_h_act;
      r_vblank_p1 <= !w_v_act;
      r_hsync_p1  <= SP ? w_hs : !w_hs;
      r_vsync_p1  <= SP ? w_vs : !w_vs;
      r_uflow_p1  <= w_uflow;
    end
  end

  assign vid_data      = r_data_p1;
  assign vid_datavalid = r_vld_p1;
  assign vid_h         = r_hblank_p1;
  assign vid_v         = r_vblank_p1;
  assign vid_h_sync    = r_hsync_p1;
  assign vid_v_sync    = r_vsync_p1;
  assign vid_f         = 1'b0;
  assign underflow     = r_uflow_p1;
  assign locked        = (r_state == ST_RUN);

endmodule
